// File: rtl/mul_arb.sv
// mul_arb: two requesters share one external pipelined multiplier. Round-robin issue,
// an owner/tag pipe that tracks in-flight ops, and credit-limited per-requester result FIFOs.
module mul_arb #(
    parameter int XLEN  = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ReqValid,
    output logic [1:0]            ReqReady,
    input  logic [1:0][XLEN-1:0]  ReqSrcA,
    input  logic [1:0][XLEN-1:0]  ReqSrcB,
    input  logic [1:0][2:0]       ReqFunct3,
    input  logic [1:0][TAGW-1:0]  ReqTag,
    input  logic [1:0]            ReqFlush,
    output logic [1:0]            RspValid,
    input  logic [1:0]            RspReady,
    output logic [1:0][XLEN-1:0]  RspResult,
    output logic [1:0][TAGW-1:0]  RspTag,
    output logic [XLEN-1:0]       MulSrcA,
    output logic [XLEN-1:0]       MulSrcB,
    output logic [2:0]            MulFunct3,
    input  logic [2*XLEN-1:0]     MulProd
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // ReqReady is this cycle's grant; RspValid means the FIFO head is present.

    logic [1:0]           eligible, grant, pop, push;
    logic                 last_grant, gsel;
    logic [1:0][CW-1:0]   credit, count, wr_idx;

    logic [LAT-1:0]             pipe_v, pipe_own, pipe_hi;
    logic [LAT-1:0][TAGW-1:0]   pipe_tag;
    logic                       ret_v, ret_own;
    logic [XLEN-1:0]            ret_data;

    logic [1:0][DEPTH-1:0][XLEN-1:0] fifo_data;
    logic [1:0][DEPTH-1:0][TAGW-1:0] fifo_tag;

    assign eligible = ReqValid & ~ReqFlush & {2{reset}} & {credit[1] != '0, credit[0] != '0};

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    assign gsel     = grant[1];
    assign ReqReady = grant;

    always_comb begin
        MulSrcA   = '0;
        MulSrcB   = '0;
        MulFunct3 = '0;
        if (|grant) begin
            MulSrcA   = ReqSrcA[gsel];
            MulSrcB   = ReqSrcB[gsel];
            MulFunct3 = ReqFunct3[gsel];
        end
    end

    // A flush of the owner kills an op in every pipe stage, including the one retiring now.
    assign ret_own  = pipe_own[LAT-1];
    assign ret_v    = pipe_v[LAT-1] & ~ReqFlush[ret_own];
    assign ret_data = pipe_hi[LAT-1] ? MulProd[2*XLEN-1:XLEN] : MulProd[XLEN-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v     <= '0;
            pipe_own   <= '0;
            pipe_hi    <= '0;
            pipe_tag   <= '0;
            last_grant <= 1'b1;
        end else begin
            pipe_v[0]   <= |grant;
            pipe_own[0] <= gsel;
            pipe_hi[0]  <= |ReqFunct3[gsel][1:0];
            pipe_tag[0] <= ReqTag[gsel];
            for (int s = 1; s < LAT; s++) begin
                pipe_v[s]   <= pipe_v[s-1] & ~ReqFlush[pipe_own[s-1]];
                pipe_own[s] <= pipe_own[s-1];
                pipe_hi[s]  <= pipe_hi[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
            if (|grant)
                last_grant <= gsel;
        end
    end

    assign RspValid  = {count[1] != '0, count[0] != '0};
    assign pop       = RspValid & RspReady;
    assign push      = {ret_v & ret_own, ret_v & ~ret_own};
    assign RspResult = {fifo_data[1][0], fifo_data[0][0]};
    assign RspTag    = {fifo_tag[1][0], fifo_tag[0][0]};
    assign wr_idx[0] = count[0] - CW'(pop[0]);
    assign wr_idx[1] = count[1] - CW'(pop[1]);

    // Head is always entry 0; a pop shifts the rest down and a same-cycle push lands behind it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            credit    <= {2{FULL}};
            fifo_data <= '0;
            fifo_tag  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ReqFlush[i]) begin
                    count[i]  <= '0;
                    credit[i] <= FULL;
                end else begin
                    if (pop[i]) begin
                        for (int k = 0; k < DEPTH - 1; k++) begin
                            fifo_data[i][k] <= fifo_data[i][k+1];
                            fifo_tag[i][k]  <= fifo_tag[i][k+1];
                        end
                    end
                    for (int k = 0; k < DEPTH; k++) begin
                        if (push[i] && wr_idx[i] == CW'(k)) begin
                            fifo_data[i][k] <= ret_data;
                            fifo_tag[i][k]  <= pipe_tag[LAT-1];
                        end
                    end
                    count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                    if (grant[i] && !pop[i] && credit[i] != '0)
                        credit[i] <= credit[i] - 1'b1;
                    else if (pop[i] && !grant[i] && credit[i] != FULL)
                        credit[i] <= credit[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_chk
        a_fifo_ovf: assert property (@(posedge clk) disable iff (!reset)
            !(push[g] && !pop[g] && count[g] == FULL));
        a_credit_max: assert property (@(posedge clk) disable iff (!reset) credit[g] <= FULL);
    end

    a_funct3: assert property (@(posedge clk) disable iff (!reset) (|grant) |-> !MulFunct3[2]);

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed and random stimulus for mul_arb, checked against a queue model of
// each requester's outstanding ops; a two-stage multiplier stub sits on the Mul* ports.
module tb_mul_arb;
    localparam int XLEN  = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
    localparam int TAGW  = 4;
    localparam int W     = 32 + TAGW + XLEN;   // {ready cycle, tag, result}

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]            req_valid, req_ready, req_flush, rsp_valid, rsp_ready;
    logic [1:0][XLEN-1:0]  req_a, req_b, rsp_result;
    logic [1:0][2:0]       req_f3;
    logic [1:0][TAGW-1:0]  req_tag, rsp_tag;
    logic [XLEN-1:0]       mul_a, mul_b;
    logic [2:0]            mul_f3;
    logic [2*XLEN-1:0]     mul_prod, m1, m2;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic         model_last;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mul_arb #(.XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .reset(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqSrcA(req_a), .ReqSrcB(req_b), .ReqFunct3(req_f3), .ReqTag(req_tag),
        .ReqFlush(req_flush),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspResult(rsp_result), .RspTag(rsp_tag),
        .MulSrcA(mul_a), .MulSrcB(mul_b), .MulFunct3(mul_f3), .MulProd(mul_prod)
    );

    // Multiplier stub: operands extended per signedness, product after two register stages.
    function automatic logic [63:0] stub_mul(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
        logic [63:0] ea, eb;
        ea = (f[1:0] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = (f[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        m1 <= stub_mul(mul_a, mul_b, mul_f3);
        m2 <= m1;
    end
    assign mul_prod = m2;

    // Reference: unsigned product, with signed upper halves obtained by subtracting corrections.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] f);
        logic [63:0] pu;
        logic [31:0] hi;
        pu = {32'b0, a} * {32'b0, b};
        hi = pu[63:32];
        case (f)
            2'b00:   return pu[31:0];
            2'b01:   return hi - (a[31] ? b : 32'd0) - (b[31] ? a : 32'd0);
            2'b10:   return hi - (a[31] ? b : 32'd0);
            default: return hi;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [W-1:0] qfront(input int i);
        return (i == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic qpush(input int i, input logic [W-1:0] e);
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic qpop(input int i);
        if (i == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic qclear(input int i);
        if (i == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    function automatic logic [1:0] pred_grant();
        logic [1:0] el;
        for (int i = 0; i < 2; i++)
            el[i] = rst_n && req_valid[i] && !req_flush[i] && (qsize(i) < DEPTH);
        if (el == 2'b11) return model_last ? 2'b01 : 2'b10;
        return el;
    endfunction

    function automatic logic [1:0] pred_valid();
        logic [1:0]   v;
        logic [W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0;
            if (rst_n && qsize(i) > 0) begin
                e = qfront(i);
                v[i] = (int'(e[W-1 -: 32]) <= cyc);
            end
        end
        return v;
    endfunction

    // Check outputs mid-cycle, advance the model across the next edge, return 1 after it.
    task automatic step();
        logic [1:0]   g, v;
        logic [W-1:0] e;
        #1;
        g = pred_grant();
        v = pred_valid();
        chk("req_ready", 96'(req_ready), 96'(g));
        chk("rsp_valid", 96'(rsp_valid), 96'(v));
        for (int i = 0; i < 2; i++) begin
            if (v[i]) begin
                e = qfront(i);
                chk($sformatf("rsp_result%0d", i), 96'(rsp_result[i]), 96'(e[XLEN-1:0]));
                chk($sformatf("rsp_tag%0d", i), 96'(rsp_tag[i]), 96'(e[XLEN +: TAGW]));
            end
        end
        if (|g)
            chk("mul_bus", 96'({mul_a, mul_b, mul_f3}),
                96'({req_a[g[1]], req_b[g[1]], req_f3[g[1]]}));
        else
            chk("mul_idle", 96'({mul_a, mul_b, mul_f3}), 96'(0));
        if (!rst_n) begin
            qclear(0);
            qclear(1);
            model_last = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_flush[i]) begin
                    qclear(i);
                end else begin
                    if (v[i] && rsp_ready[i]) qpop(i);
                    if (g[i]) qpush(i, {32'(cyc + 1 + LAT), req_tag[i],
                                        ref_result(req_a[i], req_b[i], req_f3[i][1:0])});
                end
            end
            if (|g) model_last = g[1];
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic single_op(input logic r, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f, input logic [3:0] tag,
                             input logic [31:0] exp);
        req_valid[r] = 1'b1;
        req_a[r]     = a;
        req_b[r]     = b;
        req_f3[r]    = f;
        req_tag[r]   = tag;
        rsp_ready[r] = 1'b1;
        step();
        req_valid[r] = 1'b0;
        step();
        chk("lat_early", 96'(rsp_valid[r]), 96'(0));
        step();
        chk("lat_valid", 96'(rsp_valid[r]), 96'(1));
        chk("op_result", 96'(rsp_result[r]), 96'(exp));
        chk("op_tag", 96'(rsp_tag[r]), 96'(tag));
        step();
        chk("op_popped", 96'(rsp_valid[r]), 96'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_flush = 2'b00;
        rsp_ready = 2'b00;
        req_a = '0;
        req_b = '0;
        req_f3 = '0;
        req_tag = '0;
        model_last = 1'b1;

        #2;
        chk("reset_ready", 96'(req_ready), 96'(0));
        chk("reset_rsp", 96'(rsp_valid), 96'(0));
        chk("reset_mul", 96'({mul_a, mul_b, mul_f3}), 96'(0));
        step();
        step();
        rst_n = 1'b1;
        req_valid = 2'b00;
        step();

        // Single ops: low product and each upper-half flavour.
        single_op(1'b0, 32'd3, 32'd5, 3'b000, 4'd1, 32'h0000_000F);
        single_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 4'd2, 32'h0000_0000);
        single_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 4'd3, 32'hFFFF_FFFE);
        single_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 4'd4, 32'hFFFF_FFFF);

        // Contention: alternate grants starting with req0.
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_tag[0] = 4'(4 + k);
            req_tag[1] = 4'(8 + k);
            req_a[0] = $urandom;
            req_a[1] = $urandom;
            #1;
            chk("rr_grant", 96'(req_ready), (k % 2 == 0) ? 96'(2'b01) : 96'(2'b10));
            step();
        end
        req_valid = 2'b00;
        repeat (5) step();

        // Credit exhaustion on req0 while req1 still gets through.
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_tag[0] = 4'd9;
        #1 chk("blk_acc0", 96'(req_ready), 96'(2'b01));
        step();
        req_tag[0] = 4'd10;
        #1 chk("blk_acc1", 96'(req_ready), 96'(2'b01));
        step();
        req_tag[0] = 4'd11;
        req_tag[1] = 4'd3;
        req_valid = 2'b11;
        #1 chk("blk_other", 96'(req_ready), 96'(2'b10));
        step();
        req_valid = 2'b01;
        repeat (2) begin
            #1 chk("blk_stall", 96'(req_ready), 96'(2'b00));
            step();
        end
        rsp_ready = 2'b11;
        #1 chk("blk_pop_cycle", 96'(req_ready), 96'(2'b00));
        step();
        #1 chk("blk_third", 96'(req_ready), 96'(2'b01));
        step();
        req_valid = 2'b00;
        repeat (6) step();

        // Flush of req1 right after its issue; req0 keeps its result.
        req_valid = 2'b01;
        req_a[0] = 32'd7;
        req_b[0] = 32'd6;
        req_f3[0] = 3'b000;
        req_tag[0] = 4'd13;
        step();
        req_valid = 2'b10;
        req_a[1] = 32'h1234_5678;
        req_b[1] = 32'd9;
        req_tag[1] = 4'd12;
        #1 chk("fl_issue", 96'(req_ready), 96'(2'b10));
        step();
        req_flush = 2'b10;
        #1 chk("fl_block", 96'(req_ready), 96'(2'b00));
        step();
        req_flush = 2'b00;
        req_valid = 2'b00;
        chk("fl_keep0", 96'(rsp_valid[0]), 96'(1));
        chk("fl_keep0_res", 96'(rsp_result[0]), 96'(42));
        chk("fl_keep0_tag", 96'(rsp_tag[0]), 96'(13));
        repeat (4) begin
            chk("fl_gone1", 96'(rsp_valid[1]), 96'(0));
            step();
        end
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1 chk("fl_cred_a", 96'(req_ready), 96'(2'b10));
        step();
        #1 chk("fl_cred_b", 96'(req_ready), 96'(2'b10));
        step();
        #1 chk("fl_cred_c", 96'(req_ready), 96'(2'b00));
        step();

        // Both flushes on an empty req0 and a full req1, then refill for the reset test.
        req_valid = 2'b00;
        req_flush = 2'b11;
        step();
        req_flush = 2'b00;
        req_valid = 2'b10;
        step();
        step();
        req_valid = 2'b01;
        step();
        step();

        // Asynchronous reset with both FIFOs and the pipe occupied.
        rst_n = 1'b0;
        req_valid = 2'b11;
        qclear(0);
        qclear(1);
        model_last = 1'b1;
        #1;
        chk("rst_rsp", 96'(rsp_valid), 96'(2'b00));
        chk("rst_ready", 96'(req_ready), 96'(2'b00));
        step();
        step();
        rst_n = 1'b1;
        #1 chk("rst_first", 96'(req_ready), 96'(2'b01));
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_a[i]     = pick();
                req_b[i]     = pick();
                req_f3[i]    = 3'($urandom_range(0, 3));
                req_tag[i]   = 4'($urandom);
                req_flush[i] = ($urandom_range(0, 19) == 0);
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
            end
            step();
        end
        req_valid = 2'b00;
        req_flush = 2'b00;
        rsp_ready = 2'b11;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
